wb_sched: RTL and testbench
===========================

# wb_sched

Writeback scheduler and register scoreboard for the single-write-port integer register file. Merges the in-order execute pipe's writeback and the long-latency unit's (load/mul/div) out-of-order results onto one write port. Tracks destinations of in-flight long-latency ops and stalls decode on RAW/WAW hazards, outstanding-op overflow, and long-unit starvation.

## Interface
- MAX_OUTSTANDING, 4, maximum long-latency ops in flight (≥1)
- STARVE_LIMIT, 8, consecutive refused long-unit cycles before decode is throttled (≥1)
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- dec_valid  in  1  decode holds an instruction this cycle
- dec_rs1, dec_rs2  in  5 each  source registers (x0 = no source)
- dec_rd  in  5  destination (x0 = no write)
- dec_long  in  1  instruction retires via long-latency unit
- dec_stall  out  1  decode must hold; fire = dec_valid & ~dec_stall
- ex_valid  in  1  execute-pipe writeback valid (cannot be back-pressured)
- ex_rd  in  5  execute-pipe destination
- ex_data  in  32  execute-pipe result
- lu_valid  in  1  long-unit result valid
- lu_rd  in  5  long-unit destination
- lu_data  in  32  long-unit result
- lu_ready  out  1  long-unit result accepted this cycle (lu_acc = lu_valid & lu_ready)
- wen  out  1  register-file write enable
- wreg  out  5  register-file write address
- wdata  out  32  register-file write data

## Operation
- Arbitration, combinational: ex_valid has absolute priority → wen=1, wreg=ex_rd, wdata=ex_data, lu_ready=0. Otherwise lu_ready=1; wen=lu_valid, wreg=lu_rd, wdata=lu_data.
- Write with rd=x0 is passed through; the register file discards it.
- Scoreboard busy[31:1]: set on fire & dec_long & dec_rd≠0; cleared on lu_acc & lu_rd≠0. Set and clear of the same register in one cycle → set wins.
- Outstanding counter oc, width $clog2(MAX_OUTSTANDING+1): +1 on fire & dec_long, −1 on lu_acc, both → unchanged. lu_acc with oc=0 is a protocol error (sim assertion).
- Hazard mask eff_busy = busy & ~clr, where clr is this cycle's lu_acc clear; the register file forwards same-cycle writes, so a retiring register releases decode in the same cycle.
- dec_stall = dec_valid & (eff_busy[rs1] | eff_busy[rs2] | eff_busy[rd] | (dec_long & oc==MAX_OUTSTANDING) | starve). x0 never hits. rd check enforces WAW ordering, so ex and lu never target the same live register.
- Starvation counter sc: +1 (saturating at STARVE_LIMIT) each cycle lu_valid & ~lu_ready; cleared on lu_acc or ~lu_valid. starve = (sc==STARVE_LIMIT); it stalls all decode until lu_acc, letting the execute pipe drain.

## Timing
- Arbitration, lu_ready, wen/wreg/wdata and dec_stall: combinational, zero latency; register write lands at the next clk edge.
- busy, oc, sc update at clk edge.
- Reset (any cycle, including mid-operation): busy=0, oc=0, sc=0. While reset_n=0: wen=0, lu_ready=0, dec_stall=1, wreg=0, wdata=0. In-flight long results are discarded; the long unit is flushed by the same reset.
- Worst-case long-unit wait: STARVE_LIMIT cycles plus execute-pipe depth.

## Structure
- core_pkg: XLEN=32, REG_ADDR_W=5, and the x0 constant. Shared with the register file and decode.
- Sub-module wb_scoreboard: holds busy[31:1] and oc, with set/clear/hazard-lookup ports. wb_sched holds the arbitration logic and sc.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with ex_valid=1 → wen=0, lu_ready=0, dec_stall=1; after release, busy=0 and oc=0.
- RAW: fire long op rd=x5; next decode rs1=x5 → dec_stall=1 until lu_acc of rd=5, data 0xDEADBEEF. In the lu_acc cycle, dec_stall=0, wen=1, wreg=5, wdata=0xDEADBEEF.
- Priority: ex_valid (rd=3, 0x11) and lu_valid (rd=7, 0x22) in the same cycle → wreg=3, lu_ready=0. In the next cycle without ex: wreg=7, lu_ready=1.
- Starvation: ex_valid held high and lu_valid held high → dec_stall=1 from the 9th cycle (STARVE_LIMIT=8). Dropping ex_valid → lu_acc, sc=0, and the stall released.
- Capacity/WAW: 4 long ops to x1..x4 → a 5th long op stalls (oc=4). A non-long op with rd=x2 stalls until x2 retires. A simultaneous retire of x1 and issue of a long op to x1 leaves busy[1]=1 and oc unchanged.

Source files
------------

// File: rtl/core_pkg.sv
// Shared integer-core definitions: datapath width, register addressing and
// the writeback source selector.
package core_pkg;
   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]       xlen_t;

   localparam reg_addr_t REG_X0 = '0;

   typedef enum logic {
      WB_SRC_EX,
      WB_SRC_LU
   } wb_src_e;
endpackage

// File: rtl/wb_scoreboard.sv
// Busy-register scoreboard and outstanding long-op counter; answers the
// decode hazard lookup against this cycle's retire-adjusted busy mask.
module wb_scoreboard
   import core_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       issue_en,
   input  logic [4:0] issue_rd,
   input  logic       retire_en,
   input  logic [4:0] retire_rd,
   input  logic [4:0] rs1,
   input  logic [4:0] rs2,
   input  logic [4:0] rd,
   output logic       hazard,
   output logic       full
);
   localparam int unsigned OC_W = $clog2(MAX_OUTSTANDING + 1);

   logic [31:1]     busy;
   logic [31:1]     set_vec;
   logic [31:1]     clr_vec;
   logic [31:0]     eff_busy;
   logic [OC_W-1:0] oc;

   // Decoded vectors start at x1, so x0 can never be set or hit.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      for (int unsigned i = 1; i < 32; i++) begin
         if (issue_en && issue_rd == 5'(i))   set_vec[i] = 1'b1;
         if (retire_en && retire_rd == 5'(i)) clr_vec[i] = 1'b1;
      end
   end

   always_comb begin
      eff_busy = {busy & ~clr_vec, 1'b0};
      hazard   = eff_busy[rs1] | eff_busy[rs2] | eff_busy[rd];
      full     = (oc == OC_W'(MAX_OUTSTANDING));
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         busy <= '0;
         oc   <= '0;
      end else begin
         busy <= (busy & ~clr_vec) | set_vec;
         case ({issue_en, retire_en})
            2'b10:   oc <= oc + 1'b1;
            2'b01:   oc <= oc - 1'b1;
            default: oc <= oc;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n) begin
         assert (!(retire_en && oc == '0));
      end
   end
endmodule

// File: rtl/wb_sched.sv
// Writeback scheduler: merges execute-pipe and long-unit results onto the
// single register-file write port and stalls decode on hazards/starvation.
module wb_sched
   import core_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned STARVE_LIMIT    = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        dec_valid,
   input  logic [4:0]  dec_rs1,
   input  logic [4:0]  dec_rs2,
   input  logic [4:0]  dec_rd,
   input  logic        dec_long,
   output logic        dec_stall,
   input  logic        ex_valid,
   input  logic [4:0]  ex_rd,
   input  logic [31:0] ex_data,
   input  logic        lu_valid,
   input  logic [4:0]  lu_rd,
   input  logic [31:0] lu_data,
   output logic        lu_ready,
   output logic        wen,
   output logic [4:0]  wreg,
   output logic [31:0] wdata
);
   localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

   wb_src_e         src;
   logic            lu_acc;
   logic            fire;
   logic            hazard;
   logic            full;
   logic            starve;
   logic [SC_W-1:0] sc;

   assign src    = ex_valid ? WB_SRC_EX : WB_SRC_LU;
   assign lu_acc = lu_valid & lu_ready;
   assign fire   = dec_valid & ~dec_stall;
   assign starve = (sc == SC_W'(STARVE_LIMIT));

   always_comb begin
      wen       = 1'b0;
      wreg      = REG_X0;
      wdata     = '0;
      lu_ready  = 1'b0;
      dec_stall = 1'b1;
      if (reset_n) begin
         if (src == WB_SRC_EX) begin
            wen   = 1'b1;
            wreg  = ex_rd;
            wdata = ex_data;
         end else begin
            lu_ready = 1'b1;
            wen      = lu_valid;
            wreg     = lu_rd;
            wdata    = lu_data;
         end
         dec_stall = dec_valid & (hazard | (dec_long & full) | starve);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n || lu_acc || !lu_valid) begin
         sc <= '0;
      end else if (!starve) begin
         sc <= sc + 1'b1;
      end
   end

   wb_scoreboard #(
      .MAX_OUTSTANDING(MAX_OUTSTANDING)
   ) u_sb (
      .clk       (clk),
      .reset_n   (reset_n),
      .issue_en  (fire & dec_long),
      .issue_rd  (dec_rd),
      .retire_en (lu_acc),
      .retire_rd (lu_rd),
      .rs1       (dec_rs1),
      .rs2       (dec_rs2),
      .rd        (dec_rd),
      .hazard    (hazard),
      .full      (full)
   );
endmodule

// File: tb/tb_wb_sched.sv
// Directed bench for wb_sched: reset, RAW, priority, starvation, capacity/WAW.
module tb_wb_sched;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        dec_valid, dec_long, dec_stall;
   logic [4:0]  dec_rs1, dec_rs2, dec_rd;
   logic        ex_valid;
   logic [4:0]  ex_rd;
   logic [31:0] ex_data;
   logic        lu_valid, lu_ready;
   logic [4:0]  lu_rd;
   logic [31:0] lu_data;
   logic        wen;
   logic [4:0]  wreg;
   logic [31:0] wdata;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   wb_sched #(
      .MAX_OUTSTANDING(4),
      .STARVE_LIMIT(8)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .dec_rd(dec_rd), .dec_long(dec_long), .dec_stall(dec_stall),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data),
      .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data),
      .lu_ready(lu_ready), .wen(wen), .wreg(wreg), .wdata(wdata)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      dec_valid = 1'b0; dec_long = 1'b0;
      dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
      ex_valid = 1'b0; ex_rd = '0; ex_data = '0;
      lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
   endtask

   task automatic decode(input logic lng, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd);
      dec_valid = 1'b1; dec_long = lng;
      dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd;
   endtask

   task automatic lu_drive(input logic [4:0] rd, input logic [31:0] d);
      lu_valid = 1'b1; lu_rd = rd; lu_data = d;
   endtask

   initial begin
      idle();
      reset_n = 1'b0;
      ex_valid = 1'b1; ex_rd = 5'd3; ex_data = 32'h55;
      tick();
      check("rst_wen", {31'b0, wen}, 32'd0);
      check("rst_lu_ready", {31'b0, lu_ready}, 32'd0);
      check("rst_dec_stall", {31'b0, dec_stall}, 32'd1);
      check("rst_wreg", {27'b0, wreg}, 32'd0);
      check("rst_wdata", wdata, 32'd0);
      tick();
      reset_n = 1'b1;
      idle();
      tick();
      check("rst_busy", {1'b0, dut.u_sb.busy}, 32'd0);
      check("rst_oc", 32'(dut.u_sb.oc), 32'd0);

      // RAW on x5
      decode(1'b1, 5'd0, 5'd0, 5'd5);
      #1 check("raw_issue_stall", {31'b0, dec_stall}, 32'd0);
      tick();
      decode(1'b0, 5'd5, 5'd0, 5'd6);
      #1 check("raw_hold0", {31'b0, dec_stall}, 32'd1);
      tick();
      check("raw_hold1", {31'b0, dec_stall}, 32'd1);
      tick();
      lu_drive(5'd5, 32'hDEADBEEF);
      #1;
      check("raw_release", {31'b0, dec_stall}, 32'd0);
      check("raw_wen", {31'b0, wen}, 32'd1);
      check("raw_wreg", {27'b0, wreg}, 32'd5);
      check("raw_wdata", wdata, 32'hDEADBEEF);
      check("raw_lu_ready", {31'b0, lu_ready}, 32'd1);
      tick();
      idle();
      #1 check("raw_oc", 32'(dut.u_sb.oc), 32'd0);

      // Priority: ex beats lu
      decode(1'b1, 5'd0, 5'd0, 5'd7);
      tick();
      idle();
      ex_valid = 1'b1; ex_rd = 5'd3; ex_data = 32'h11;
      lu_drive(5'd7, 32'h22);
      #1;
      check("pri_wreg_ex", {27'b0, wreg}, 32'd3);
      check("pri_wdata_ex", wdata, 32'h11);
      check("pri_lu_ready_ex", {31'b0, lu_ready}, 32'd0);
      tick();
      ex_valid = 1'b0;
      #1;
      check("pri_wreg_lu", {27'b0, wreg}, 32'd7);
      check("pri_wdata_lu", wdata, 32'h22);
      check("pri_lu_ready_lu", {31'b0, lu_ready}, 32'd1);
      tick();
      idle();

      // Starvation: stall from the 9th refused cycle
      decode(1'b1, 5'd0, 5'd0, 5'd9);
      tick();
      decode(1'b0, 5'd0, 5'd0, 5'd11);
      ex_valid = 1'b1; ex_rd = 5'd10; ex_data = 32'hA5;
      lu_drive(5'd9, 32'h99);
      for (int k = 1; k <= 10; k++) begin
         #1 check($sformatf("starve_c%0d", k), {31'b0, dec_stall}, (k >= 9) ? 32'd1 : 32'd0);
         tick();
      end
      ex_valid = 1'b0;
      #1;
      check("starve_acc_ready", {31'b0, lu_ready}, 32'd1);
      check("starve_acc_wreg", {27'b0, wreg}, 32'd9);
      check("starve_acc_stall", {31'b0, dec_stall}, 32'd1);
      tick();
      lu_valid = 1'b0;
      #1;
      check("starve_sc", 32'(dut.sc), 32'd0);
      check("starve_released", {31'b0, dec_stall}, 32'd0);
      tick();
      idle();

      // Capacity and WAW
      for (int r = 1; r <= 4; r++) begin
         decode(1'b1, 5'd0, 5'd0, 5'(r));
         #1 check($sformatf("cap_issue_x%0d", r), {31'b0, dec_stall}, 32'd0);
         tick();
      end
      decode(1'b1, 5'd0, 5'd0, 5'd8);
      #1;
      check("cap_oc4", 32'(dut.u_sb.oc), 32'd4);
      check("cap_fifth_stall", {31'b0, dec_stall}, 32'd1);
      decode(1'b0, 5'd0, 5'd0, 5'd2);
      #1 check("waw_x2_stall", {31'b0, dec_stall}, 32'd1);
      decode(1'b0, 5'd0, 5'd0, 5'd12);
      #1 check("cap_short_ok", {31'b0, dec_stall}, 32'd0);
      tick();
      decode(1'b0, 5'd0, 5'd0, 5'd2);
      lu_drive(5'd2, 32'h2222);
      #1 check("waw_x2_release", {31'b0, dec_stall}, 32'd0);
      tick();
      decode(1'b1, 5'd0, 5'd0, 5'd1);
      lu_drive(5'd1, 32'h1111);
      #1 check("setclr_stall", {31'b0, dec_stall}, 32'd0);
      tick();
      idle();
      #1;
      check("setclr_busy1", {31'b0, dut.u_sb.busy[1]}, 32'd1);
      check("setclr_oc", 32'(dut.u_sb.oc), 32'd3);
      lu_drive(5'd1, 32'h1);
      tick();
      lu_drive(5'd3, 32'h3);
      tick();
      lu_drive(5'd4, 32'h4);
      #1 check("drain_wreg", {27'b0, wreg}, 32'd4);
      tick();
      idle();
      #1;
      check("drain_oc", 32'(dut.u_sb.oc), 32'd0);
      check("drain_busy", {1'b0, dut.u_sb.busy}, 32'd0);

      // Mid-operation reset clears scoreboard
      decode(1'b1, 5'd0, 5'd0, 5'd5);
      tick();
      idle();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      #1;
      check("midrst_busy", {1'b0, dut.u_sb.busy}, 32'd0);
      check("midrst_oc", 32'(dut.u_sb.oc), 32'd0);
      decode(1'b0, 5'd5, 5'd0, 5'd6);
      #1 check("midrst_no_stall", {31'b0, dec_stall}, 32'd0);
      tick();
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
